li_rr_merge: RTL and testbench
==============================

# li_rr_merge

- Round-robin merge that shares one downstream li_link channel (valid/data/stop) among N upstream li_link producers.
- Used in front of a shared relay-station chain or shell input port.
- Holds a registered grant pointer and a 2-entry output buffer, so every upstream stop is a registered (Moore) signal and there is no combinational path from any input to any stop.
- Sustains one token per cycle, tags each token with its source index, and is fair under contention.

## Interface
Parameters:
- WIDTH, 6, payload width per token
- N, 4, number of upstream producers (2..16)
- SW, $clog2(N), width of source index

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous, active-high reset
- in_data  input  N*WIDTH  producer i payload at bits [i*WIDTH +: WIDTH]
- in_valid  input  N  producer i token valid
- in_stop  output  N  stop to producer i
- out_data  output  WIDTH  head-of-buffer payload
- out_src  output  SW  source index of the head token
- out_valid  output  1  head token valid
- out_stop  input  1  downstream back-pressure
- grant  output  SW  current grant pointer g (debug/observability)

## Operation
- Transfer rule on every link: a token moves in a cycle where valid=1 and stop=0. Otherwise it is not consumed, and the producer may hold or drop it.
- Buffer: 2-entry FIFO of {data, src} with count 0..2 and full = (count==2).
  - Push when in_valid[g] & ~in_stop[g].
  - Pop when out_valid & ~out_stop.
- Stop generation:
  - in_stop[i] = 1 for all i != g.
  - in_stop[g] = full.
  - Both are decoded from registers only.
- Outputs:
  - out_valid = (count != 0).
  - out_data and out_src come from the head entry. They hold their last value when count==0.
- Grant update, evaluated each cycle from the current in_valid:
  - If in_valid[g]=1 and full: g holds.
  - Otherwise the next g is the first index with in_valid=1, searching g+1, g+2, …, N-1, 0, …, g (g is checked last).
  - If no in_valid bit is set: g holds.
- Consequences of the grant rule:
  - A sole active producer keeps the grant and streams at full rate.
  - Under contention, grants rotate one token per producer.
  - An idle granted producer loses the grant in one cycle.
- Simultaneous events:
  - Push and pop with count==1: count stays 1; the new token becomes head next cycle.
  - Push and pop with count==0 cannot occur (no pop possible).
  - Pop with count==2: count becomes 1; in_stop[g] deasserts next cycle.
  - Push is impossible while count==2.
- Ordering: tokens leave in acceptance order. Per-source order is preserved.

## Timing
- Reset (asynchronous, takes effect immediately):
  - g=0, count=0, out_valid=0, out_data=0, out_src=0, grant=0.
  - in_stop = all ones except bit 0 = 0.
  - Buffered tokens are discarded on reset mid-operation.
- Latency: a token accepted in cycle t is presented on out_* in cycle t+1 when the buffer was empty.
- Grant switch latency: 1 cycle from the cycle a new producer's in_valid is sampled to its in_stop deasserting.
- After downstream stop rises, the buffer absorbs at most one further token. in_stop[g] rises the cycle after count reaches 2.
- Throughput: 1 token/cycle when out_stop=0 and a valid token is on the granted input every cycle.
- Combinational paths: in_stop and out_valid have none from inputs. Only the push/pop enables, the next-count logic and the next-grant logic are combinational.

## Test plan
- Reset mid-stream with count=2:
  - Required: out_valid=0 immediately; in_stop=4'b1110 (N=4); grant=0.
  - Required: the next token from producer 0 appears at t+1 after acceptance.
- Single producer 2 streams 0x01..0x08 with out_stop=0:
  - Required: grant reaches 2 one cycle after the first valid.
  - Required: then 8 consecutive out_valid cycles, data 0x01..0x08, out_src=2, no bubbles.
- All 4 producers continuously valid, out_stop=0:
  - Required: out_src sequence 0,1,2,3,0,1,… (after reset g=0) with one token per cycle.
  - Required: each producer receives exactly 25% of 40 tokens.
- Back-pressure with producer 1 streaming:
  - Stimulus: hold out_stop=1 for 5 cycles.
  - Required: count reaches 2; in_stop[1] high from the cycle after full.
  - Required: no token loss or duplication. After release, the buffered tokens drain in order, then streaming resumes at full rate.
- Idle skip:
  - Stimulus: g=3, in_valid=4'b0100.
  - Required: grant becomes 2 in one cycle. It does not visit 0 or 1.
- Grant hold when full:
  - Stimulus: g=0, in_valid=4'b1111, out_stop=1 long enough to fill.
  - Required: grant stays 0 while full, then advances to 1 on the first cycle producer 0 is accepted after release.

Source files
------------

// File: rtl/li_rr_merge.sv
// li_rr_merge: round-robin merge of N li_link producers onto one channel.
// Registered grant and 2-entry buffer keep every upstream stop Moore.
module li_rr_merge #(
    parameter int WIDTH = 6,
    parameter int N = 4,
    parameter int SW = $clog2(N)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N*WIDTH-1:0] in_data,
    input  logic [N-1:0]       in_valid,
    output logic [N-1:0]       in_stop,
    output logic [WIDTH-1:0]   out_data,
    output logic [SW-1:0]      out_src,
    output logic               out_valid,
    input  logic               out_stop,
    output logic [SW-1:0]      grant
);
    logic [SW-1:0]    g, g_next, idx;
    logic [1:0]       count;
    logic [WIDTH-1:0] head_data, tail_data, sel_data;
    logic [SW-1:0]    head_src, tail_src;
    logic             full, push, pop, found;

    assign full     = count == 2'd2;
    assign push     = in_valid[g] & ~full;
    assign pop      = (count != 2'd0) & ~out_stop;
    assign sel_data = in_data[int'(g)*WIDTH +: WIDTH];

    // Search g+1 .. g with wraparound; g itself is checked last.
    always_comb begin
        g_next = g;
        idx = g;
        found = 1'b0;
        for (int k = 1; k <= N; k++) begin
            idx = SW'((int'(g) + k) % N);
            if (!found && in_valid[idx]) begin
                g_next = idx;
                found = 1'b1;
            end
        end
        if (in_valid[g] && full) g_next = g;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            g <= '0;
            count <= 2'd0;
            head_data <= '0;
            head_src <= '0;
            tail_data <= '0;
            tail_src <= '0;
        end else begin
            g <= g_next;
            count <= count + 2'(push) - 2'(pop);
            if (push && (count == 2'd0 || pop)) begin
                head_data <= sel_data;
                head_src <= g;
            end else if (pop && full) begin
                head_data <= tail_data;
                head_src <= tail_src;
            end
            if (push && count == 2'd1 && !pop) begin
                tail_data <= sel_data;
                tail_src <= g;
            end
        end
    end

    for (genvar i = 0; i < N; i++) begin : g_stop
        assign in_stop[i] = (g != SW'(i)) || full;
    end

    assign out_valid = count != 2'd0;
    assign out_data  = head_data;
    assign out_src   = head_src;
    assign grant     = g;
endmodule

// File: tb/tb_li_rr_merge.sv
// tb_li_rr_merge: directed table plus hand sequences for li_rr_merge (N=4, WIDTH=6).
module tb_li_rr_merge;
    logic        clk, reset;
    logic [23:0] in_data;
    logic [3:0]  in_valid, in_stop;
    logic [5:0]  out_data;
    logic [1:0]  out_src, grant;
    logic        out_valid, out_stop;
    int          checks = 0, errors = 0;

    typedef struct {
        logic [3:0] v;
        logic [5:0] b;
        logic       st;
        logic       ev;
        logic [5:0] ed;
        logic [1:0] es;
        logic [1:0] eg;
        logic [3:0] eis;
    } vec_t;
    vec_t tbl[14];

    li_rr_merge #(.WIDTH(6), .N(4)) dut (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
        .in_stop(in_stop), .out_data(out_data), .out_src(out_src),
        .out_valid(out_valid), .out_stop(out_stop), .grant(grant)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [23:0] pack(input logic [5:0] b);
        logic [23:0] r;
        for (int i = 0; i < 4; i++) r[i*6 +: 6] = b + 6'(i);
        return r;
    endfunction

    task automatic do_reset();
        reset = 1'b1;
        in_valid = 4'b0;
        in_data = 24'b0;
        out_stop = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not end");
        $fatal(1, "timeout");
    end

    initial begin
        int tally[4];
        int p, exp_tok, acc, pops;
        tbl[0]  = '{4'b0100, 6'd0,  1'b0, 1'b0, 6'd0,  2'd0, 2'd2, 4'b1011};
        tbl[1]  = '{4'b0100, 6'd10, 1'b0, 1'b1, 6'd12, 2'd2, 2'd2, 4'b1011};
        tbl[2]  = '{4'b1000, 6'd20, 1'b0, 1'b0, 6'd12, 2'd2, 2'd3, 4'b0111};
        tbl[3]  = '{4'b0100, 6'd30, 1'b0, 1'b0, 6'd12, 2'd2, 2'd2, 4'b1011};
        tbl[4]  = '{4'b0000, 6'd0,  1'b0, 1'b0, 6'd12, 2'd2, 2'd2, 4'b1011};
        tbl[5]  = '{4'b0001, 6'd1,  1'b0, 1'b0, 6'd12, 2'd2, 2'd0, 4'b1110};
        tbl[6]  = '{4'b0001, 6'd1,  1'b1, 1'b1, 6'd1,  2'd0, 2'd0, 4'b1110};
        tbl[7]  = '{4'b0001, 6'd2,  1'b1, 1'b1, 6'd1,  2'd0, 2'd0, 4'b1111};
        tbl[8]  = '{4'b1111, 6'd10, 1'b1, 1'b1, 6'd1,  2'd0, 2'd0, 4'b1111};
        tbl[9]  = '{4'b1111, 6'd10, 1'b1, 1'b1, 6'd1,  2'd0, 2'd0, 4'b1111};
        tbl[10] = '{4'b1111, 6'd20, 1'b0, 1'b1, 6'd2,  2'd0, 2'd0, 4'b1110};
        tbl[11] = '{4'b1111, 6'd30, 1'b0, 1'b1, 6'd30, 2'd0, 2'd1, 4'b1101};
        tbl[12] = '{4'b1111, 6'd40, 1'b0, 1'b1, 6'd41, 2'd1, 2'd2, 4'b1011};
        tbl[13] = '{4'b0000, 6'd0,  1'b0, 1'b0, 6'd41, 2'd1, 2'd2, 4'b1011};

        do_reset();
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_grant", 32'(grant), 32'd0);
        check("rst_stop", 32'(in_stop), 32'hE);
        check("rst_data", 32'(out_data), 32'd0);
        check("rst_src", 32'(out_src), 32'd0);

        for (int n = 0; n < 14; n++) begin
            @(negedge clk);
            in_valid = tbl[n].v;
            in_data = pack(tbl[n].b);
            out_stop = tbl[n].st;
            @(posedge clk);
            #1;
            check($sformatf("tbl%0d_valid", n), 32'(out_valid), 32'(tbl[n].ev));
            check($sformatf("tbl%0d_data", n), 32'(out_data), 32'(tbl[n].ed));
            check($sformatf("tbl%0d_src", n), 32'(out_src), 32'(tbl[n].es));
            check($sformatf("tbl%0d_grant", n), 32'(grant), 32'(tbl[n].eg));
            check($sformatf("tbl%0d_stop", n), 32'(in_stop), 32'(tbl[n].eis));
        end

        do_reset();
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            in_valid = (c <= 8) ? 4'b0100 : 4'b0000;
            in_data = 24'(c == 0 ? 1 : c) << 12;
            @(posedge clk);
            #1;
            if (c == 0) check("stream_grant", 32'(grant), 32'd2);
            else if (c <= 8) begin
                check($sformatf("stream%0d_valid", c), 32'(out_valid), 32'd1);
                check($sformatf("stream%0d_data", c), 32'(out_data), 32'(c));
                check($sformatf("stream%0d_src", c), 32'(out_src), 32'd2);
            end else check("stream_end_valid", 32'(out_valid), 32'd0);
        end

        do_reset();
        tally = '{0, 0, 0, 0};
        in_valid = 4'b1111;
        in_data = pack(6'd16);
        for (int c = 0; c < 40; c++) begin
            @(posedge clk);
            #1;
            check($sformatf("rr%0d_valid", c), 32'(out_valid), 32'd1);
            check($sformatf("rr%0d_src", c), 32'(out_src), 32'(c % 4));
            check($sformatf("rr%0d_data", c), 32'(out_data), 32'(16 + c % 4));
            if (out_valid) tally[out_src]++;
        end
        for (int i = 0; i < 4; i++) check($sformatf("rr_share%0d", i), 32'(tally[i]), 32'd10);

        do_reset();
        p = 1;
        exp_tok = 1;
        acc = 0;
        pops = 0;
        for (int c = 0; c <= 20; c++) begin
            @(negedge clk);
            out_stop = (c >= 5 && c <= 9);
            in_valid = (c <= 19) ? 4'b0010 : 4'b0000;
            in_data = 24'(p) << 6;
            if (c >= 1 && c <= 19)
                check($sformatf("bp%0d_stop1", c), 32'(in_stop[1]), 32'(c >= 6 && c <= 10));
            if (c >= 2) check($sformatf("bp%0d_valid", c), 32'(out_valid), 32'd1);
            if (out_valid && !out_stop) begin
                check($sformatf("bp%0d_order", c), 32'(out_data), 32'(exp_tok));
                exp_tok++;
                pops++;
            end
            if (in_valid[1] && !in_stop[1]) begin
                p++;
                acc++;
            end
            @(posedge clk);
        end
        @(negedge clk);
        check("bp_pops", 32'(pops), 32'd14);
        check("bp_accepted", 32'(acc), 32'd14);
        check("bp_drained", 32'(out_valid), 32'd0);

        do_reset();
        in_valid = 4'b0001;
        in_data = pack(6'd5);
        out_stop = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("mid_full_stop", 32'(in_stop), 32'hF);
        check("mid_full_data", 32'(out_data), 32'd5);
        #2;
        reset = 1'b1;
        #1;
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        check("mid_rst_stop", 32'(in_stop), 32'hE);
        check("mid_rst_grant", 32'(grant), 32'd0);
        check("mid_rst_data", 32'(out_data), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        in_valid = 4'b0001;
        in_data = pack(6'd42);
        out_stop = 1'b0;
        @(posedge clk);
        #1;
        check("post_rst_valid", 32'(out_valid), 32'd1);
        check("post_rst_data", 32'(out_data), 32'd42);
        check("post_rst_src", 32'(out_src), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
